// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
// Signal names keep the responder's point of view: i_* are driven by the master, o_* by the slave.
interface dmem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [2:0]        i_req_funct3;
  logic [ADDR_W-1:0] i_req_addr;
  logic [31:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;

  modport master (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: word-organised little-endian RAM answering RV32I
// byte/half/word loads and stores, with a fixed number of wait states per access and
// error reporting for misaligned, out-of-range and illegal-size requests.
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  // Control and captured request
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  // Registered outputs
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  // Storage (not reset)
  logic [31:0]       r_mem [0:DEPTH_WORDS-1];

  // Access decode
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_lane;
  logic              w_oob;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_err;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;
  logic              w_do_write;

  assign bus.o_req_ready = r_req_ready;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_rdata = r_rsp_rdata;
  assign bus.o_rsp_err   = r_rsp_err;

  // Decode the captured request into word index, lane, error flag, load data and store lanes.
  always_comb begin
    w_idx    = r_addr[IDX_W+1:2];
    w_lane   = r_addr[1:0];
    // Any address bit above the RAM index range makes the access out of range.
    w_oob    = ((r_addr >> (IDX_W + 2)) != {ADDR_W{1'b0}});
    w_word   = r_mem[w_idx];
    w_half   = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_byte   = w_word[7:0];
    w_err    = 1'b1;
    w_load   = 32'd0;
    w_be     = 4'b0000;
    w_wlanes = 32'd0;

    case (w_lane)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase

    case (r_funct3)
      3'b000: begin
        w_err    = w_oob;
        w_load   = {{24{w_byte[7]}}, w_byte};
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{r_wdata[7:0]}};
      end
      3'b001: begin
        w_err    = w_oob | w_lane[0];
        w_load   = {{16{w_half[15]}}, w_half};
        w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      3'b010: begin
        w_err    = w_oob | (w_lane != 2'd0);
        w_load   = w_word;
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
      end
      3'b100: begin
        // Unsigned sizes exist only for loads.
        w_err    = w_oob | r_we;
        w_load   = {24'd0, w_byte};
      end
      3'b101: begin
        w_err    = w_oob | r_we | w_lane[0];
        w_load   = {16'd0, w_half};
      end
      default: begin
        w_err    = 1'b1;
        w_load   = 32'd0;
      end
    endcase

    if ((r_state == S_ACCESS) && r_we && !w_err) begin
      w_do_write = 1'b1;
    end else begin
      w_do_write = 1'b0;
    end
  end

  // RAM write: only the selected byte lanes of a legal store are updated.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_do_write && w_be[i]) begin
        r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  // Request/response sequencer: accept, wait, access, then hold the response until taken.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= 32'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_req_ready) begin
            // First cycle out of reset: advertise readiness.
            r_req_ready <= 1'b1;
          end else if (bus.i_req_valid) begin
            r_we        <= bus.i_req_we;
            r_funct3    <= bus.i_req_funct3;
            r_addr      <= bus.i_req_addr;
            r_wdata     <= bus.i_req_wdata;
            r_req_ready <= 1'b0;
            r_cnt       <= WAIT_INIT;
            r_state     <= NO_WAIT ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Stores and errors both return zero data.
          r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
          r_rsp_err   <= w_err;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two builds (2 and 0 wait states) driven by request tasks,
// a byte-array reference model producing expected responses into per-DUT queues,
// and a monitor that checks latency, hold stability and response contents.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;
  localparam int NBYTES = DEPTH * 4;
  localparam int WA     = 2;
  localparam int WB     = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    longint      acc;
  } exp_t;

  logic   clk  = 1'b0;
  logic   rstn = 1'b0;
  longint cyc  = 0;
  int     n_tests = 0;
  int     n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.ADDR_W(ADDR_W)) bus0 ();
  dmem_responder_if #(.ADDR_W(ADDR_W)) bus1 ();

  dmem_responder #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) u_dut_w2 (
    .i_clk(clk), .i_rstn(rstn), .bus(bus0)
  );
  dmem_responder #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WB)) u_dut_w0 (
    .i_clk(clk), .i_rstn(rstn), .bus(bus1)
  );

  logic        d_valid [2];
  logic        d_we    [2];
  logic [2:0]  d_f3    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        d_rready[2];
  bit          rand_bp [2];

  logic        m_req_ready[2];
  logic        m_rsp_valid[2];
  logic [31:0] m_rsp_rdata[2];
  logic        m_rsp_err  [2];

  assign bus0.i_req_valid  = d_valid[0];
  assign bus0.i_req_we     = d_we[0];
  assign bus0.i_req_funct3 = d_f3[0];
  assign bus0.i_req_addr   = d_addr[0];
  assign bus0.i_req_wdata  = d_wdata[0];
  assign bus0.i_rsp_ready  = d_rready[0];
  assign bus1.i_req_valid  = d_valid[1];
  assign bus1.i_req_we     = d_we[1];
  assign bus1.i_req_funct3 = d_f3[1];
  assign bus1.i_req_addr   = d_addr[1];
  assign bus1.i_req_wdata  = d_wdata[1];
  assign bus1.i_rsp_ready  = d_rready[1];

  assign m_req_ready[0] = bus0.o_req_ready;
  assign m_rsp_valid[0] = bus0.o_rsp_valid;
  assign m_rsp_rdata[0] = bus0.o_rsp_rdata;
  assign m_rsp_err[0]   = bus0.o_rsp_err;
  assign m_req_ready[1] = bus1.o_req_ready;
  assign m_rsp_valid[1] = bus1.o_rsp_valid;
  assign m_rsp_rdata[1] = bus1.o_rsp_rdata;
  assign m_rsp_err[1]   = bus1.o_rsp_err;

  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] ref_mem [0:1][0:NBYTES-1];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @cyc %0d: got %h, expected %h", name, d, cyc, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    if (d == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t qfront(input int d);
    if (d == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  // Reference model: byte-addressed memory, sizes and errors derived directly from the rules.
  task automatic model(input int d, input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int     nb;
    bit     bad;
    longint v;
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad = 0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) bad = 1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) bad = 1;
    if ((a % nb) != 0) bad = 1;
    if (a >= NBYTES) bad = 1;
    rd  = 32'd0;
    err = bad;
    if (!bad) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[d][a + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v + (longint'(ref_mem[d][a + i]) << (8 * i));
        if (!f3[2] && nb < 4 && ref_mem[d][a + nb - 1][7]) v = v - (longint'(1) << (8 * nb));
        rd = v[31:0];
      end
    end
  endtask

  // Issue one request when the DUT is ready; expected response goes to the scoreboard.
  task automatic do_req(input int d, input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!m_req_ready[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!m_req_ready[d]) begin
      chk("req_ready_timeout", d, 32'(m_req_ready[d]), 32'd1);
      return;
    end
    model(d, we, f3, a, wd, e.rdata, e.err);
    e.acc = cyc + 1;
    qpush(d, e);
    d_valid[d] = 1'b1;
    d_we[d]    = we;
    d_f3[d]    = f3;
    d_addr[d]  = a;
    d_wdata[d] = wd;
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs after acceptance; they must not influence the access.
    d_valid[d] = 1'b0;
    d_we[d]    = 1'($urandom);
    d_f3[d]    = 3'($urandom);
    d_addr[d]  = $urandom;
    d_wdata[d] = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      chk("drain_timeout", 0, 32'(q0.size() + q1.size()), 32'd0);
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  // Monitor state
  bit          prev_v  [2];
  bit          held    [2];
  bit          after_hs[2];
  logic [31:0] h_rd    [2];
  logic        h_err   [2];

  task automatic mon_step(input int d);
    exp_t e;
    int   w;
    w = (d == 0) ? WA : WB;
    if (!rstn) begin
      prev_v[d]   = 0;
      held[d]     = 0;
      after_hs[d] = 0;
      return;
    end
    if (after_hs[d]) begin
      chk("post_hs_valid", d, 32'(m_rsp_valid[d]), 32'd0);
      chk("post_hs_req_ready", d, 32'(m_req_ready[d]), 32'd1);
      after_hs[d] = 0;
    end
    if (m_rsp_valid[d]) begin
      chk("busy_req_ready", d, 32'(m_req_ready[d]), 32'd0);
      if (qsize(d) == 0) begin
        chk("unexpected_rsp", d, 32'(m_rsp_valid[d]), 32'd0);
      end else begin
        e = qfront(d);
        if (!prev_v[d]) chk("latency", d, 32'(cyc - e.acc), 32'(w + 1));
        if (held[d]) begin
          chk("hold_rdata", d, m_rsp_rdata[d], h_rd[d]);
          chk("hold_err", d, 32'(m_rsp_err[d]), 32'(h_err[d]));
        end
        if (d_rready[d]) begin
          chk("rdata", d, m_rsp_rdata[d], e.rdata);
          chk("err", d, 32'(m_rsp_err[d]), 32'(e.err));
          qpop(d);
          held[d]     = 0;
          after_hs[d] = 1;
        end else begin
          held[d]  = 1;
          h_rd[d]  = m_rsp_rdata[d];
          h_err[d] = m_rsp_err[d];
        end
      end
    end
    prev_v[d] = m_rsp_valid[d];
  endtask

  // Check responses on the falling edge, away from the DUT's sampling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  // Random response back-pressure, changed just after the rising edge.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rand_bp[d]) d_rready[d] = 1'($urandom_range(0, 1));
    end
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus.
  initial begin
    int   t;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      d_valid[d]  = 1'b0;
      d_we[d]     = 1'b0;
      d_f3[d]     = 3'd0;
      d_addr[d]   = 32'd0;
      d_wdata[d]  = 32'd0;
      d_rready[d] = 1'b1;
      rand_bp[d]  = 0;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", d, 32'(m_req_ready[d]), 32'd0);
      chk("rst_rsp_valid", d, 32'(m_rsp_valid[d]), 32'd0);
      chk("rst_rsp_rdata", d, m_rsp_rdata[d], 32'd0);
      chk("rst_rsp_err", d, 32'(m_rsp_err[d]), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("ready_after_release", d, 32'(m_req_ready[d]), 32'd1);

    // Directed loads/stores on the 2-wait-state build.
    do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(0, 0, 3'b010, 32'h10, 32'h0);
    do_req(0, 1, 3'b000, 32'h11, 32'h0000007F);
    do_req(0, 0, 3'b010, 32'h10, 32'h0);
    do_req(0, 0, 3'b000, 32'h13, 32'h0);
    do_req(0, 0, 3'b100, 32'h13, 32'h0);
    do_req(0, 0, 3'b001, 32'h12, 32'h0);
    do_req(0, 0, 3'b101, 32'h12, 32'h0);
    // Error cases, then confirm memory untouched.
    do_req(0, 0, 3'b001, 32'h11, 32'h0);
    do_req(0, 0, 3'b010, 32'h12, 32'h0);
    do_req(0, 1, 3'b100, 32'h10, 32'h12345678);
    do_req(0, 0, 3'b011, 32'h10, 32'h0);
    do_req(0, 1, 3'b010, 32'h1000, 32'hCAFEF00D);
    do_req(0, 0, 3'b010, 32'h1000, 32'h0);
    do_req(0, 0, 3'b010, 32'h10, 32'h0);
    drain();

    // Back-pressure: hold the response for several cycles, then release.
    d_rready[0] = 1'b0;
    do_req(0, 0, 3'b010, 32'h10, 32'h0);
    t = 0;
    while (!m_rsp_valid[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", 0, 32'(m_rsp_valid[0]), 32'd1);
    repeat (5) @(negedge clk);
    chk("bp_still_valid", 0, 32'(m_rsp_valid[0]), 32'd1);
    @(posedge clk);
    #1 d_rready[0] = 1'b1;
    drain();

    // Zero-wait build: store then load a stream of 8 words.
    for (int i = 0; i < 8; i++) do_req(1, 1, 3'b010, 32'(32'h40 + 4 * i), $urandom);
    for (int i = 0; i < 8; i++) do_req(1, 0, 3'b010, 32'(32'h40 + 4 * i), 32'h0);
    drain();

    // Initialise a 256-byte window in both builds, then random traffic with back-pressure.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++) do_req(d, 1, 3'b010, 32'(4 * w), $urandom);
    end
    drain();
    rand_bp[0] = 1;
    rand_bp[1] = 1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 15))
        0:       a = $urandom | 32'h0000_1000;
        1:       a = 32'h1000 + 32'($urandom_range(0, 7));
        default: a = 32'($urandom_range(0, 255));
      endcase
      do_req(n % 2, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    drain();
    rand_bp[0] = 0;
    rand_bp[1] = 0;
    @(posedge clk);
    #1 begin
      d_rready[0] = 1'b1;
      d_rready[1] = 1'b1;
    end
    drain();

    // Reset during WAIT aborts a pending store.
    do_req(0, 1, 3'b010, 32'h20, 32'h11111111);
    drain();
    t = 0;
    while (!m_req_ready[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    d_valid[0] = 1'b1;
    d_we[0]    = 1'b1;
    d_f3[0]    = 3'b010;
    d_addr[0]  = 32'h20;
    d_wdata[0] = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    d_valid[0] = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_rsp_valid", 0, 32'(m_rsp_valid[0]), 32'd0);
    chk("abort_req_ready", 0, 32'(m_req_ready[0]), 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_rsp", 0, 32'(m_rsp_valid[0]), 32'd0);
    do_req(0, 0, 3'b010, 32'h20, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
